// File: rtl/scan_mux_pkg.sv
// rtl/scan_mux_pkg.sv - shared mode encoding for the scan_mux block
package scan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_mux_next_ch.sv
// rtl/scan_mux_next_ch.sv - combinational circular next-unmasked-channel finder
module scan_mux_next_ch
  import scan_mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [SEL_W-1:0] ch,
  input  logic [N_CH-1:0]  ch_mask,
  output logic [SEL_W-1:0] nxt,
  output logic             none_set
);

  // Search ch+1, ch+2, ... circularly (ch itself last); the descending loop lets the nearest hit win.
  always_comb begin
    int idx;
    idx      = 0;
    nxt      = '0;
    none_set = 1'b1;
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(ch) + k) % N_CH;
      if (!ch_mask[idx]) begin
        nxt      = SEL_W'(idx);
        none_set = 1'b0;
      end
    end
  end

endmodule

// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - registered N:1 mux with manual select and round-robin scan (optional SCAN_MUX_MASK_EN adds ch_mask)
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int N_CH    = 8,
  parameter int W       = 1,
  parameter int DWELL_W = 4,
  parameter int SEL_W   = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH*W-1:0]   din,
  input  logic                en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel_in,
  input  logic [DWELL_W-1:0]  dwell,
`ifdef SCAN_MUX_MASK_EN
  input  logic [N_CH-1:0]     ch_mask,
`endif
  output logic [W-1:0]        dout,
  output logic [SEL_W-1:0]    sel_out,
  output logic                dout_valid,
  output logic                frame_start
);

  logic [W-1:0]       r_dout;
  logic [SEL_W-1:0]   r_sel_out;
  logic               r_dout_valid;
  logic               r_frame_start;
  logic [SEL_W-1:0]   r_ch;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_mode_prev;

  logic [N_CH-1:0]    w_mask;
  logic               w_scan_first;
  logic [SEL_W-1:0]   w_first_ch;
  logic               w_none_first;
  logic [SEL_W-1:0]   w_cur_ch;
  logic [DWELL_W-1:0] w_cur_cnt;
  logic [SEL_W-1:0]   w_next_ch;
  logic               w_none_adv;
  logic               w_all_masked;
  logic               w_cnt_done;
  logic               w_man_legal;
  logic [W-1:0]       w_man_data;
  logic [W-1:0]       w_scan_data;

`ifdef SCAN_MUX_MASK_EN
  assign w_mask = ch_mask;
`else
  assign w_mask = '0;
`endif

  // Out-of-range selects return zero instead of reading past the packed input.
  function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] d, input logic [SEL_W-1:0] s);
    pick = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (s == SEL_W'(k)) pick = d[k*W +: W];
    end
  endfunction

  // Lowest unmasked channel = the circular successor of the last channel.
  scan_mux_next_ch #(.N_CH(N_CH), .SEL_W(SEL_W)) u_first (
    .ch       (SEL_W'(N_CH-1)),
    .ch_mask  (w_mask),
    .nxt      (w_first_ch),
    .none_set (w_none_first)
  );

  scan_mux_next_ch #(.N_CH(N_CH), .SEL_W(SEL_W)) u_adv (
    .ch       (w_cur_ch),
    .ch_mask  (w_mask),
    .nxt      (w_next_ch),
    .none_set (w_none_adv)
  );

  // Entering scan mode starts a fresh frame regardless of stale counter contents.
  assign w_scan_first = (r_mode_prev != MODE_SCAN);
  assign w_cur_ch     = w_scan_first ? w_first_ch : r_ch;
  assign w_cur_cnt    = w_scan_first ? '0 : r_cnt;
  assign w_all_masked = w_none_first | w_none_adv;
  // >= so that shrinking dwell below the running count advances at once.
  assign w_cnt_done   = (w_cur_cnt >= dwell);
  assign w_man_legal  = (int'(sel_in) < N_CH);
  assign w_man_data   = pick(din, sel_in);
  assign w_scan_data  = pick(din, w_cur_ch);

  // Output registers plus channel/dwell counters; en low freezes everything but the strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout        <= '0;
      r_sel_out     <= '0;
      r_dout_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_ch          <= '0;
      r_cnt         <= '0;
      r_mode_prev   <= MODE_MANUAL;
    end else if (!en) begin
      r_dout_valid  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (mode == MODE_MANUAL) begin
      r_dout        <= w_man_legal ? w_man_data : '0;
      r_sel_out     <= sel_in;
      r_dout_valid  <= w_man_legal;
      r_frame_start <= 1'b0;
      r_ch          <= '0;
      r_cnt         <= '0;
      r_mode_prev   <= MODE_MANUAL;
    end else if (w_all_masked) begin
      r_dout        <= '0;
      r_dout_valid  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_dout        <= w_scan_data;
      r_sel_out     <= w_cur_ch;
      r_dout_valid  <= 1'b1;
      r_frame_start <= (w_cur_ch == w_first_ch) && (w_cur_cnt == '0);
      r_mode_prev   <= MODE_SCAN;
      if (w_cnt_done) begin
        r_cnt <= '0;
        r_ch  <= w_next_ch;
      end else begin
        r_cnt <= w_cur_cnt + DWELL_W'(1);
      end
    end
  end

  assign dout        = r_dout;
  assign sel_out     = r_sel_out;
  assign dout_valid  = r_dout_valid;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_scan_mux.sv
// tb/tb_scan_mux.sv - directed self-checking bench for scan_mux (N_CH=8 and N_CH=5 instances)
module tb_scan_mux;

  logic       clk;
  logic       rst_n;

  logic [7:0] a_din;
  logic       a_en;
  logic       a_mode;
  logic [2:0] a_sel;
  logic [3:0] a_dwell;
  logic       a_dout;
  logic [2:0] a_sel_out;
  logic       a_valid;
  logic       a_fs;
`ifdef SCAN_MUX_MASK_EN
  logic [7:0] a_mask;
  logic [4:0] b_mask;
`endif

  logic [4:0] b_din;
  logic       b_en;
  logic       b_mode;
  logic [2:0] b_sel;
  logic [3:0] b_dwell;
  logic       b_dout;
  logic [2:0] b_sel_out;
  logic       b_valid;
  logic       b_fs;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-decoded bits of din = 8'b11001101 (channel 0 first) and din = 5'b10110.
  int a_exp[8] = '{1, 0, 1, 1, 0, 0, 1, 1};
  int b_exp[5] = '{0, 1, 1, 0, 1};
  int m_seq[5] = '{1, 3, 4, 6, 1};
  int m_fs[5]  = '{1, 0, 0, 0, 1};

  scan_mux u_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (a_din),
    .en          (a_en),
    .mode        (a_mode),
    .sel_in      (a_sel),
    .dwell       (a_dwell),
`ifdef SCAN_MUX_MASK_EN
    .ch_mask     (a_mask),
`endif
    .dout        (a_dout),
    .sel_out     (a_sel_out),
    .dout_valid  (a_valid),
    .frame_start (a_fs)
  );

  scan_mux #(.N_CH(5)) u_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (b_din),
    .en          (b_en),
    .mode        (b_mode),
    .sel_in      (b_sel),
    .dwell       (b_dwell),
`ifdef SCAN_MUX_MASK_EN
    .ch_mask     (b_mask),
`endif
    .dout        (b_dout),
    .sel_out     (b_sel_out),
    .dout_valid  (b_valid),
    .frame_start (b_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_din = 8'b11001101; a_en = 1'b0; a_mode = 1'b0; a_sel = '0; a_dwell = '0;
    b_din = 5'b10110;    b_en = 1'b0; b_mode = 1'b0; b_sel = '0; b_dwell = '0;
`ifdef SCAN_MUX_MASK_EN
    a_mask = '0;
    b_mask = '0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dout", a_dout, 0);
    chk("rst_sel", a_sel_out, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_fs", a_fs, 0);
    chk("rst_b_valid", b_valid, 0);
    rst_n = 1'b1;

    // Manual mode, each select held 3 cycles
    a_en = 1'b1;
    a_mode = 1'b0;
    for (int s = 0; s < 8; s++) begin
      a_sel = 3'(s);
      repeat (3) begin
        @(negedge clk);
        chk($sformatf("man_dout_%0d", s), a_dout, a_exp[s]);
        chk($sformatf("man_sel_%0d", s), a_sel_out, s);
        chk($sformatf("man_valid_%0d", s), a_valid, 1);
        chk($sformatf("man_fs_%0d", s), a_fs, 0);
      end
    end

    // Scan, dwell=0: one channel per cycle, wrap after 7, frame every 8
    a_mode = 1'b1;
    a_dwell = 4'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("scan0_sel_%0d", i), a_sel_out, i % 8);
      chk($sformatf("scan0_dout_%0d", i), a_dout, a_exp[i % 8]);
      chk($sformatf("scan0_fs_%0d", i), a_fs, (i % 8 == 0) ? 1 : 0);
      chk($sformatf("scan0_valid_%0d", i), a_valid, 1);
    end

    // Dwell shrunk from 3 to 1 while the count is already 2: advance at once
    a_mode = 1'b0;
    @(negedge clk);
    a_mode = 1'b1;
    a_dwell = 4'd3;
    @(negedge clk); chk("dw_c1_sel", a_sel_out, 0); chk("dw_c1_fs", a_fs, 1);
    @(negedge clk); chk("dw_c2_sel", a_sel_out, 0); chk("dw_c2_fs", a_fs, 0);
    a_dwell = 4'd1;
    @(negedge clk); chk("dw_c3_sel", a_sel_out, 0);
    @(negedge clk); chk("dw_c4_sel", a_sel_out, 1);
    @(negedge clk); chk("dw_c5_sel", a_sel_out, 1);
    @(negedge clk); chk("dw_c6_sel", a_sel_out, 2);

    // en=0 mid-scan for 4 cycles, then resume with the same channel and count
    a_mode = 1'b0;
    @(negedge clk);
    a_mode = 1'b1;
    a_dwell = 4'd2;
    @(negedge clk); chk("fr_c1_sel", a_sel_out, 0);
    @(negedge clk); chk("fr_c2_sel", a_sel_out, 0);
    @(negedge clk); chk("fr_c3_sel", a_sel_out, 0);
    @(negedge clk); chk("fr_c4_sel", a_sel_out, 1);
    @(negedge clk); chk("fr_c5_sel", a_sel_out, 1); chk("fr_c5_dout", a_dout, 0);
    a_en = 1'b0;
    a_din = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("frz_sel_%0d", i), a_sel_out, 1);
      chk($sformatf("frz_dout_%0d", i), a_dout, 0);
      chk($sformatf("frz_valid_%0d", i), a_valid, 0);
      chk($sformatf("frz_fs_%0d", i), a_fs, 0);
    end
    a_en = 1'b1;
    @(negedge clk);
    chk("res_sel", a_sel_out, 1); chk("res_dout", a_dout, 1); chk("res_valid", a_valid, 1);
    @(negedge clk);
    chk("res2_sel", a_sel_out, 2); chk("res2_fs", a_fs, 0);

    // Asynchronous reset at ch=5, then restart from ch 0 with frame_start
    a_din = 8'b11001101;
    a_dwell = 4'd0;
    a_mode = 1'b0;
    @(negedge clk);
    a_mode = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_sel", a_sel_out, 5);
    chk("pre_rst_valid", a_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sel", a_sel_out, 0);
    chk("async_rst_valid", a_valid, 0);
    chk("async_rst_dout", a_dout, 0);
    chk("async_rst_fs", a_fs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_sel", a_sel_out, 0);
    chk("post_rst_fs", a_fs, 1);
    chk("post_rst_dout", a_dout, 1);
    @(negedge clk);
    chk("post_rst2_sel", a_sel_out, 1);
    chk("post_rst2_fs", a_fs, 0);
    a_en = 1'b0;

    // N_CH=5, dwell=2: 3 cycles per channel, wrap 4->0, frame period 15
    b_en = 1'b1;
    b_mode = 1'b1;
    b_dwell = 4'd2;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk($sformatf("b_sel_%0d", i), b_sel_out, (i / 3) % 5);
      chk($sformatf("b_dout_%0d", i), b_dout, b_exp[(i / 3) % 5]);
      chk($sformatf("b_fs_%0d", i), b_fs, (i % 15 == 0) ? 1 : 0);
    end

    // N_CH=5 manual: last legal select, then out-of-range select
    b_mode = 1'b0;
    b_sel = 3'd4;
    @(negedge clk);
    chk("b_man4_dout", b_dout, 1); chk("b_man4_valid", b_valid, 1);
    b_sel = 3'd6;
    @(negedge clk);
    chk("b_man6_dout", b_dout, 0); chk("b_man6_valid", b_valid, 0); chk("b_man6_sel", b_sel_out, 6);

`ifdef SCAN_MUX_MASK_EN
    // Masked scan: channels 0,2,5,7 skipped
    a_en = 1'b1;
    a_mode = 1'b0;
    @(negedge clk);
    a_mask = 8'b10100101;
    a_mode = 1'b1;
    a_dwell = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("mask_sel_%0d", i), a_sel_out, m_seq[i]);
      chk($sformatf("mask_fs_%0d", i), a_fs, m_fs[i]);
      chk($sformatf("mask_dout_%0d", i), a_dout, a_exp[m_seq[i]]);
    end
    a_mask = 8'hFF;
    @(negedge clk);
    chk("mask_all_valid", a_valid, 0);
    chk("mask_all_dout", a_dout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
